// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG host driver: command encoding, host FSM states
// and the fixed TMS sequence lengths.
package jtag_pkg;

  typedef enum logic [1:0] {
    CMD_IR_SCAN   = 2'd0,
    CMD_DR_SCAN   = 2'd1,
    CMD_TAP_RESET = 2'd2,
    CMD_RESERVED  = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    RESET_SEQ = 2'd0,
    IDLE      = 2'd1,
    SCAN      = 2'd2,
    RESP      = 2'd3
  } host_state_e;

  // TAP reset: tms=1 for RESET_TMS_ONES edges, then one tms=0 edge.
  localparam int unsigned RESET_TMS_ONES = 5;
  localparam int unsigned RESET_EDGES    = 6;
  // Edges before the first shift edge (Run-Test/Idle -> Shift-xR).
  localparam int unsigned DR_PRE_EDGES   = 3;
  localparam int unsigned IR_PRE_EDGES   = 4;
  // Edges after the last shift edge (Exit1 -> Update -> Run-Test/Idle).
  localparam int unsigned POST_EDGES     = 2;

endpackage

// File: rtl/jtag_host_driver_if.sv
// Command/response bus of the JTAG host driver.
// Handshake: a transfer happens on the rising clk edge where valid and ready are
// both high; the sender holds valid and its payload stable until that edge.
interface jtag_host_driver_if #(
  parameter int DR_MAX = 32
);
  localparam int LEN_W = $clog2(DR_MAX + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [LEN_W-1:0]  cmd_len;
  logic [DR_MAX-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DR_MAX-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles tck every CLK_DIV clk cycles while enabled, low otherwise.
// rise/fall are high in the clk cycle whose closing edge moves tck up/down.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic tl_reset,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             wrap;

  assign wrap = en && (cnt_q == LAST);
  assign rise = wrap && !tck_q;
  assign fall = wrap && tck_q;
  assign tck  = tck_q;

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      tck_d = !tck_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge tl_reset) begin
    if (tl_reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG host: runs TAP reset, IR scan and DR scan sequences from a command bus and
// returns captured TDO bits. The target TAP sits in Run-Test/Idle whenever idle.
module jtag_host_driver
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 2,
  parameter int DR_MAX   = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                tl_reset,
  jtag_host_driver_if.slave   bus,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo,
  output host_state_e         dbg_state
);
  localparam int LEN_W = $clog2(DR_MAX + 1);
  localparam int CNT_W = $clog2(DR_MAX + IR_WIDTH + 8);

  host_state_e       state_q, state_d;
  cmd_type_e         kind_q, kind_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [DR_MAX-1:0] data_q, data_d;
  logic [DR_MAX-1:0] mask_q, mask_d;
  logic [DR_MAX-1:0] cap_q, cap_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DR_MAX-1:0] rsp_data_q, rsp_data_d;

  logic              tck_en, tck_rise, tck_fall;
  logic              cmd_ready;
  cmd_type_e         cmd_kind;
  logic              cmd_bad;
  logic              is_rst;
  logic [CNT_W-1:0]  shift_lo, shift_hi, total;
  logic              in_shift;
  logic              tms_next, tdi_next;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .tl_reset (tl_reset),
    .en       (tck_en),
    .tck      (tck),
    .rise     (tck_rise),
    .fall     (tck_fall)
  );

  assign tck_en    = (state_q == RESET_SEQ) || (state_q == SCAN);
  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
  assign cmd_kind  = cmd_type_e'(bus.cmd_type);
  assign cmd_bad   = (cmd_kind == CMD_RESERVED) ||
                     ((cmd_kind == CMD_DR_SCAN) &&
                      ((bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(DR_MAX))));

  // edge_q is the index of the next tck rising edge of the running sequence.
  assign is_rst   = (state_q == RESET_SEQ) || (kind_q == CMD_TAP_RESET);
  assign shift_lo = (kind_q == CMD_IR_SCAN) ? CNT_W'(IR_PRE_EDGES) : CNT_W'(DR_PRE_EDGES);
  assign shift_hi = shift_lo + len_q;
  assign total    = is_rst ? CNT_W'(RESET_EDGES) : shift_hi + CNT_W'(POST_EDGES);
  assign in_shift = !is_rst && (edge_q >= shift_lo) && (edge_q < shift_hi);
  assign tdi_next = in_shift && data_q[0];

  always_comb begin
    tms_next = 1'b0;
    if (is_rst) begin
      tms_next = edge_q < CNT_W'(RESET_TMS_ONES);
    end else if (edge_q < shift_lo) begin
      tms_next = (edge_q == '0) || ((kind_q == CMD_IR_SCAN) && (edge_q == CNT_W'(1)));
    end else if (in_shift) begin
      tms_next = edge_q == (shift_hi - CNT_W'(1));
    end else begin
      tms_next = edge_q == shift_hi;
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    len_d       = len_q;
    edge_d      = edge_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cap_d       = cap_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      RESET_SEQ, SCAN: begin
        if (tck_rise) begin
          edge_d = edge_q + CNT_W'(1);
          if (in_shift) begin
            data_d = data_q >> 1;
            cap_d  = cap_q | (mask_q & {DR_MAX{tdo}});
            mask_d = mask_q << 1;
          end
        end else if (tck_fall) begin
          if (edge_q == total) begin
            // Every sequence starts with tms=1, so idle with tms already high.
            tms_d  = 1'b1;
            tdi_d  = 1'b0;
            edge_d = '0;
            if (state_q == RESET_SEQ) begin
              state_d = IDLE;
            end else begin
              state_d    = RESP;
              rsp_data_d = cap_q;
              rsp_err_d  = 1'b0;
            end
          end else begin
            tms_d = tms_next;
            tdi_d = tdi_next;
          end
        end
      end
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          kind_d = cmd_kind;
          data_d = bus.cmd_data;
          mask_d = {{(DR_MAX-1){1'b0}}, 1'b1};
          cap_d  = '0;
          edge_d = '0;
          len_d  = (cmd_kind == CMD_IR_SCAN) ? CNT_W'(IR_WIDTH) : CNT_W'(bus.cmd_len);
          if (cmd_bad) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = RESET_SEQ;
    endcase
  end

  always_ff @(posedge clk or posedge tl_reset) begin
    if (tl_reset) begin
      state_q     <= RESET_SEQ;
      kind_q      <= CMD_TAP_RESET;
      len_q       <= '0;
      edge_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      len_q       <= len_d;
      edge_q      <= edge_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver: a behavioural TAP target (2-bit IR, 1-bit bypass DR)
// hangs off the JTAG pins; responses are scored against a queue of expectations.
module tb_jtag_host_driver;
  import jtag_pkg::*;

  localparam int IR_W    = 2;
  localparam int DR_MAX  = 32;
  localparam int CLK_DIV = 3;

  typedef struct {
    logic [1:0]  typ;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_tck;
    logic [1:0]  exp_ir;
  } vec_t;

  logic        clk;
  logic        tl_reset;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;
  host_state_e dbg_state;

  jtag_host_driver_if #(.DR_MAX(DR_MAX)) bus ();

  jtag_host_driver #(.IR_WIDTH(IR_W), .DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .tl_reset  (tl_reset),
    .bus       (bus),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // target TAP model: states 0..15 in the usual JTAG order
  logic [3:0] tap_st = 4'd0;
  logic [1:0] ir_sr  = 2'b00;
  logic [1:0] tap_ir = 2'b11;
  logic       byp    = 1'b0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      4'd0:  return m ? 4'd0  : 4'd1;
      4'd1:  return m ? 4'd2  : 4'd1;
      4'd2:  return m ? 4'd9  : 4'd3;
      4'd3:  return m ? 4'd5  : 4'd4;
      4'd4:  return m ? 4'd5  : 4'd4;
      4'd5:  return m ? 4'd8  : 4'd6;
      4'd6:  return m ? 4'd7  : 4'd6;
      4'd7:  return m ? 4'd8  : 4'd4;
      4'd8:  return m ? 4'd2  : 4'd1;
      4'd9:  return m ? 4'd0  : 4'd10;
      4'd10: return m ? 4'd12 : 4'd11;
      4'd11: return m ? 4'd12 : 4'd11;
      4'd12: return m ? 4'd15 : 4'd13;
      4'd13: return m ? 4'd14 : 4'd13;
      4'd14: return m ? 4'd15 : 4'd11;
      default: return m ? 4'd2 : 4'd1;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      4'd0:  tap_ir <= 2'b11;
      4'd3:  byp    <= 1'b0;
      4'd4:  byp    <= tdi;
      4'd10: ir_sr  <= 2'b01;
      4'd11: ir_sr  <= {tdi, ir_sr[1]};
      4'd15: tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo <= (tap_st == 4'd11) ? ir_sr[0] : (tap_st == 4'd4) ? byp : 1'b0;

  // pin monitors
  int          tck_count = 0;
  logic [63:0] tms_hist = '0;
  int          tdi_stray = 0;
  int          rsp_valid_cycles = 0;

  always @(posedge tck) begin
    tck_count <= tck_count + 1;
    tms_hist  <= {tms_hist[62:0], tms};
    if (tdi === 1'b1 && tap_st != 4'd4 && tap_st != 4'd11) tdi_stray <= tdi_stray + 1;
  end

  always @(posedge clk)
    if (bus.rsp_valid === 1'b1) rsp_valid_cycles <= rsp_valid_cycles + 1;

  // scoreboard
  logic [32:0] exp_q[$];
  int          exp_tck_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic sb_push(input logic err, input logic [31:0] data, input int ntck);
    exp_q.push_back({err, data});
    exp_tck_q.push_back(ntck);
  endtask

  // driver tasks
  task automatic send_cmd(input string name, input logic [1:0] typ, input logic [5:0] len,
                          input logic [31:0] data);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = typ;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) fail_timeout({name, "_accept"});
    else begin
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) fail_timeout({name, "_ready"});
  endtask

  task automatic collect(input string name, input int t0, input int hold);
    int          n;
    logic [32:0] exp;
    int          etck;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    exp  = exp_q.pop_front();
    etck = exp_tck_q.pop_front();
    if (n >= 3000) begin
      fail_timeout({name, "_rsp"});
      return;
    end
    check({name, "_tck"}, tck_count - t0, etck);
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, bus.rsp_valid, 1'b1);
      check({name, "_hold_data"}, bus.rsp_data, exp[31:0]);
      check({name, "_hold_ready"}, bus.cmd_ready, 1'b0);
      @(posedge clk); #1;
    end
    check({name, "_data"}, bus.rsp_data, exp[31:0]);
    check({name, "_err"}, bus.rsp_err, exp[32]);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({name, "_b2b_ready"}, bus.cmd_ready, 1'b1);
  endtask

  vec_t        vecs[10];
  int          t0, t1, rv0, n;
  logic [5:0]  r_len;
  logic [31:0] r_data;
  logic [63:0] r_mask;

  initial begin
    vecs[0] = '{2'd0, 6'd0,  32'h0000_0002, 32'h0000_0001, 1'b0, 8,  2'b10};
    vecs[1] = '{2'd1, 6'd8,  32'h0000_00A5, 32'h0000_004A, 1'b0, 13, 2'b00};
    vecs[2] = '{2'd1, 6'd0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0,  2'b00};
    vecs[3] = '{2'd1, 6'd33, 32'h0000_1234, 32'h0000_0000, 1'b1, 0,  2'b00};
    vecs[4] = '{2'd3, 6'd4,  32'h0000_000F, 32'h0000_0000, 1'b1, 0,  2'b00};
    vecs[5] = '{2'd2, 6'd8,  32'h0000_00FF, 32'h0000_0000, 1'b0, 6,  2'b00};
    vecs[6] = '{2'd1, 6'd32, 32'hDEAD_BEEF, 32'hBD5B_7DDE, 1'b0, 37, 2'b00};
    vecs[7] = '{2'd1, 6'd1,  32'h0000_0001, 32'h0000_0000, 1'b0, 6,  2'b00};
    vecs[8] = '{2'd0, 6'd0,  32'h0000_0001, 32'h0000_0001, 1'b0, 8,  2'b01};
    vecs[9] = '{2'd1, 6'd5,  32'h0000_003F, 32'h0000_001E, 1'b0, 10, 2'b00};

    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    tl_reset      = 1'b1;

    // reset values
    repeat (4) @(posedge clk);
    #1;
    check("rst_tck", tck, 1'b0);
    check("rst_tms", tms, 1'b1);
    check("rst_tdi", tdi, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_state", dbg_state, RESET_SEQ);

    // power-on TAP reset sequence
    t0 = tck_count;
    tl_reset = 1'b0;
    wait_ready("boot");
    check("boot_tck", tck_count - t0, 6);
    check("boot_tms", tms_hist[5:0], 6'b111110);
    check("boot_ready", bus.cmd_ready, 1'b1);
    check("boot_tap_rti", tap_st, 4'd1);

    // table-driven commands
    for (int i = 0; i < 10; i++) begin
      t0 = tck_count;
      sb_push(vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_tck);
      send_cmd($sformatf("vec%0d", i), vecs[i].typ, vecs[i].len, vecs[i].data);
      collect($sformatf("vec%0d", i), t0, 0);
      if (vecs[i].typ == 2'd0) check($sformatf("vec%0d_ir", i), tap_ir, vecs[i].exp_ir);
      check($sformatf("vec%0d_tap_rti", i), tap_st, 4'd1);
    end

    // random DR scans through the bypass loopback
    for (int i = 0; i < 4; i++) begin
      r_len  = 6'($urandom_range(1, 32));
      r_data = $urandom;
      r_mask = (64'h1 << r_len) - 64'h1;
      t0 = tck_count;
      sb_push(1'b0, (r_data << 1) & r_mask[31:0], int'(r_len) + 5);
      send_cmd($sformatf("rnd%0d", i), 2'd1, r_len, r_data);
      collect($sformatf("rnd%0d", i), t0, 0);
    end

    // response held back for 20 clk
    r_data = $urandom;
    t0 = tck_count;
    sb_push(1'b0, (r_data << 1) & 32'h0000_FFFF, 21);
    send_cmd("hold", 2'd1, 6'd16, r_data);
    collect("hold", t0, 20);

    // reset at shift edge 3 of a 16-bit DR scan
    rv0 = rsp_valid_cycles;
    t0  = tck_count;
    send_cmd("abort", 2'd1, 6'd16, 32'h0000_BEEF);
    n = 0;
    while (tck_count < t0 + 7 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) fail_timeout("abort_edge");
    check("abort_tck_high", tck, 1'b1);
    tl_reset = 1'b1;
    #1;
    check("abort_tck_low", tck, 1'b0);
    check("abort_tms", tms, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_state", dbg_state, RESET_SEQ);
    check("abort_ready", bus.cmd_ready, 1'b0);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    t1 = tck_count;
    tl_reset = 1'b0;
    wait_ready("abort");
    check("abort_reseq_tck", tck_count - t1, 6);
    check("abort_reseq_tms", tms_hist[5:0], 6'b111110);
    check("abort_no_rsp", rsp_valid_cycles - rv0, 0);
    check("abort_tap_rti", tap_st, 4'd1);

    // normal operation after the abort
    t0 = tck_count;
    sb_push(1'b0, 32'h0000_0006, 9);
    send_cmd("post", 2'd1, 6'd4, 32'h0000_000B);
    collect("post", t0, 0);

    check("tdi_outside_shift", tdi_stray, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
